// File: rtl/sdr_cmd_arb.sv
// SDRAM command-bus arbiter: shares one registered command bus between the init/refresh
// source and the read/write engine, tracking pending refreshes and forcing early burst stop.
`timescale 1ns/1ps
`ifndef BA_WIDTH
`define BA_WIDTH 2
`endif
`ifndef ROW_WIDTH
`define ROW_WIDTH 12
`endif

module sdr_cmd_arb #(
    parameter int unsigned REF_WIN = 20,
    parameter int unsigned RW_MAX  = 256
) (
    input  logic                   Sdr_clk,
    input  logic                   Rst,
    input  logic                   Sdr_init_done,
    input  logic                   Sdr_ref_req,
    output logic                   Sdr_ref_ack,
    input  logic                   Ir_vld,
    input  logic                   Ir_ras,
    input  logic                   Ir_cas,
    input  logic                   Ir_we,
    input  logic [`BA_WIDTH-1:0]   Ir_ba,
    input  logic [`ROW_WIDTH:0]    Ir_addr,
    input  logic                   Rw_req,
    output logic                   Rw_gnt,
    input  logic                   Rw_done,
    output logic                   Rw_stop,
    input  logic                   Rw_ras,
    input  logic                   Rw_cas,
    input  logic                   Rw_we,
    input  logic [`BA_WIDTH-1:0]   Rw_ba,
    input  logic [`ROW_WIDTH:0]    Rw_addr,
    output logic                   Sdr_rw_vld,
    output logic                   Sdr_ras,
    output logic                   Sdr_cas,
    output logic                   Sdr_we,
    output logic [`BA_WIDTH-1:0]   Sdr_ba,
    output logic [`ROW_WIDTH:0]    Sdr_addr
);

    localparam int unsigned BA_W    = `BA_WIDTH;
    localparam int unsigned AD_W    = `ROW_WIDTH + 1;
    localparam int unsigned CMD_W   = 3 + BA_W + AD_W;
    localparam int unsigned REF_CW  = $clog2(REF_WIN + 1);
    localparam int unsigned HOLD_CW = $clog2(RW_MAX + 1);
    localparam logic [CMD_W-1:0] CMD_NOP = {3'b111, {(CMD_W-3){1'b0}}};

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RW, ST_REF} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_pend;
    logic [1:0]           w_pend_nxt;
    logic [REF_CW-1:0]    r_ref_cnt;
    logic [REF_CW-1:0]    w_ref_nxt;
    logic [HOLD_CW-1:0]   r_hold;
    logic [HOLD_CW-1:0]   w_hold_nxt;
    logic                 r_ack;
    logic                 r_gnt;
    logic                 r_stop;
    logic                 w_ack_nxt;
    logic                 w_stop_nxt;
    logic [CMD_W-1:0]     r_cmd;
    logic [CMD_W-1:0]     w_cmd;
    logic [CMD_W-1:0]     w_ir_cmd;
    logic [CMD_W-1:0]     w_rw_cmd;

    assign w_ir_cmd = {Ir_ras, Ir_cas, Ir_we, Ir_ba, Ir_addr};
    assign w_rw_cmd = {Rw_ras, Rw_cas, Rw_we, Rw_ba, Rw_addr};

    always_ff @(posedge Sdr_clk) begin
        if (Rst) r_state <= ST_INIT;
        else     r_state <= w_next;
    end

    // Next state, next command and counter updates.
    always_comb begin
        w_next     = r_state;
        w_cmd      = CMD_NOP;
        w_hold_nxt = '0;
        w_ref_nxt  = '0;
        w_pend_nxt = r_pend;
        case (r_state)
            ST_INIT: begin
                if (Ir_vld) w_cmd = w_ir_cmd;
                if (Sdr_init_done) w_next = ST_IDLE;
            end
            // A refresh request seen this cycle holds off the RW grant so refresh wins ties.
            ST_IDLE: begin
                if (r_pend != 2'd0) w_next = ST_REF;
                else if (Rw_req && !Sdr_ref_req) w_next = ST_RW;
            end
            ST_RW: begin
                if (Rw_done) w_next = (r_pend != 2'd0) ? ST_REF : ST_IDLE;
                if (r_pend != 2'd0 && r_hold != HOLD_CW'(RW_MAX)) w_hold_nxt = r_hold + HOLD_CW'(1);
                else                                              w_hold_nxt = r_hold;
            end
            ST_REF: begin
                if (Ir_vld) w_cmd = w_ir_cmd;
                if (r_ref_cnt == REF_CW'(REF_WIN - 1)) w_next = ST_IDLE;
                else                                   w_ref_nxt = r_ref_cnt + REF_CW'(1);
            end
            default: w_next = ST_INIT;
        endcase
        if (!Sdr_init_done) w_next = ST_INIT;
        // The RW engine's last cycle is replaced by NOP so every hand-over has a gap.
        if (r_state == ST_RW && w_next == ST_RW) w_cmd = w_rw_cmd;
        if (w_next != ST_RW)  w_hold_nxt = '0;
        if (w_next != ST_REF) w_ref_nxt  = '0;
        if (Sdr_ref_req && !r_ack) begin
            if (r_pend != 2'd3) w_pend_nxt = r_pend + 2'd1;
        end else if (!Sdr_ref_req && r_ack && r_pend != 2'd0) begin
            w_pend_nxt = r_pend - 2'd1;
        end
        if (r_state == ST_INIT && w_next == ST_IDLE) w_pend_nxt = '0;
        w_ack_nxt  = (w_next == ST_REF) && (r_state != ST_REF);
        w_stop_nxt = (w_next == ST_RW) && (r_stop || w_hold_nxt == HOLD_CW'(RW_MAX));
    end

    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            r_pend    <= '0;
            r_ref_cnt <= '0;
            r_hold    <= '0;
            r_ack     <= 1'b0;
            r_gnt     <= 1'b0;
            r_stop    <= 1'b0;
            r_cmd     <= CMD_NOP;
        end else begin
            r_pend    <= w_pend_nxt;
            r_ref_cnt <= w_ref_nxt;
            r_hold    <= w_hold_nxt;
            r_ack     <= w_ack_nxt;
            r_gnt     <= (w_next == ST_RW);
            r_stop    <= w_stop_nxt;
            r_cmd     <= w_cmd;
        end
    end

    assign Sdr_ref_ack = r_ack;
    assign Rw_gnt      = r_gnt;
    assign Sdr_rw_vld  = r_gnt;
    assign Rw_stop     = r_stop;
    assign {Sdr_ras, Sdr_cas, Sdr_we, Sdr_ba, Sdr_addr} = r_cmd;

endmodule
